// File: rtl/hls_run_pkg.sv
// Shared types for the Bambu kernel batch-run controller: FSM states, result status codes
// and the packed result record.
package hls_run_pkg;

  typedef enum logic [2:0] {
    IDLE,
    KRST,
    START,
    WAIT,
    LOG,
    BATCH_DONE
  } state_e;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_TIMEOUT = 2'd1;

  localparam int RES_CNT_W = 32;

  typedef struct packed {
    logic [1:0]           status;
    logic [RES_CNT_W-1:0] cycles;
  } result_t;

endpackage

// File: rtl/hls_run_fifo.sv
// Synchronous first-word-fall-through FIFO with count-based full/empty.
// A push is accepted on a full FIFO when a pop happens in the same cycle.
module hls_run_fifo
  import hls_run_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 2 + RES_CNT_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          wr_en;
  logic          rd_en;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/hls_run_controller.sv
// Batch-run controller for one Bambu kernel: reset, start, time to done (with watchdog),
// log {status, cycles} into a result FIFO, repeat for the configured number of runs.
//
// state      | meaning
// IDLE       | waiting for cfg_go, kernel held in reset
// KRST       | kernel reset held low, KRST_CYC cycles via down-counter
// START      | one-cycle start pulse, cycle counter = 1
// WAIT       | counting cycles until done_port or watchdog
// LOG        | pushing the result, parks here while the FIFO is full
// BATCH_DONE | one-cycle batch_done pulse, busy dropped
module hls_run_controller
  import hls_run_pkg::*;
#(
  parameter int CNT_W      = RES_CNT_W,
  parameter int RUNS_W     = 8,
  parameter int TIMEOUT    = 200000000,
  parameter int KRST_CYC   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_go,
  input  logic [RUNS_W-1:0] cfg_num_runs,
  output logic              krn_reset,
  output logic              start_port,
  input  logic              done_port,
  output logic              busy,
  output logic              batch_done,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [1:0]        res_status,
  output logic [CNT_W-1:0]  res_cycles,
  output logic [CNT_W-1:0]  stat_min,
  output logic [CNT_W-1:0]  stat_max
);

  localparam int KW = (KRST_CYC > 1) ? $clog2(KRST_CYC) : 1;
  localparam logic [KW-1:0]    KRST_INIT = KW'(KRST_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic [KW-1:0]     krst_cnt;
  logic [RUNS_W-1:0] run_idx;
  logic [RUNS_W-1:0] num_runs;
  logic [1:0]        res_status_q;
  logic [CNT_W-1:0]  res_cycles_q;
  logic [RUNS_W:0]   run_next;
  logic              last_run;

  logic fifo_full;
  logic fifo_empty;
  logic fifo_pop;
  logic push_ok;
  logic fifo_push;

  assign fifo_pop  = res_ready && !fifo_empty;
  assign push_ok   = !fifo_full || fifo_pop;
  assign fifo_push = (state == LOG) && push_ok;
  assign res_valid = !fifo_empty;
  assign run_next  = {1'b0, run_idx} + {{RUNS_W{1'b0}}, 1'b1};
  assign last_run  = (run_next == {1'b0, num_runs});

  hls_run_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (2 + CNT_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({res_status_q, res_cycles_q}),
    .pop       (res_ready),
    .head      ({res_status, res_cycles}),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      krn_reset    <= 1'b0;
      start_port   <= 1'b0;
      busy         <= 1'b0;
      batch_done   <= 1'b0;
      cnt          <= '0;
      krst_cnt     <= '0;
      run_idx      <= '0;
      num_runs     <= '0;
      res_status_q <= ST_OK;
      res_cycles_q <= '0;
      stat_min     <= '1;
      stat_max     <= '0;
    end else begin
      batch_done <= 1'b0;
      case (state)
        IDLE: begin
          krn_reset <= 1'b0;
          if (cfg_go) begin
            if (cfg_num_runs != '0) begin
              state    <= KRST;
              busy     <= 1'b1;
              num_runs <= cfg_num_runs;
              run_idx  <= '0;
              stat_min <= '1;
              stat_max <= '0;
              krst_cnt <= KRST_INIT;
            end else begin
              state      <= BATCH_DONE;
              batch_done <= 1'b1;
            end
          end
        end

        KRST: begin
          if (krst_cnt == '0) begin
            state      <= START;
            krn_reset  <= 1'b1;
            start_port <= 1'b1;
            cnt        <= CNT_W'(1);
          end else begin
            krst_cnt <= krst_cnt - KW'(1);
          end
        end

        // START and WAIT share the sampling logic: done in the start cycle counts as 1
        START, WAIT: begin
          start_port <= 1'b0;
          if (done_port) begin
            res_status_q <= ST_OK;
            res_cycles_q <= cnt;
            state        <= LOG;
          end else if (cnt == TIMEOUT_C) begin
            res_status_q <= ST_TIMEOUT;
            res_cycles_q <= cnt;
            state        <= LOG;
          end else begin
            cnt   <= cnt + CNT_W'(1);
            state <= WAIT;
          end
        end

        LOG: begin
          if (push_ok) begin
            if (res_status_q == ST_OK) begin
              if (res_cycles_q < stat_min) stat_min <= res_cycles_q;
              if (res_cycles_q > stat_max) stat_max <= res_cycles_q;
            end
            run_idx   <= run_next[RUNS_W-1:0];
            krn_reset <= 1'b0;
            if (last_run || (res_status_q == ST_TIMEOUT)) begin
              state      <= BATCH_DONE;
              batch_done <= 1'b1;
              busy       <= 1'b0;
            end else begin
              state    <= KRST;
              krst_cnt <= KRST_INIT;
            end
          end
        end

        BATCH_DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
